// File: rtl/clk_div_pkg.sv
// Shared types for the clock-divider bank: widths, pending-slot request and slot state.
package clk_div_pkg;

  localparam int CNT_W_DEF  = 27;
  localparam int NUM_CH_MAX = 8;
  localparam int CH_IDX_W   = $clog2(NUM_CH_MAX);

  typedef logic [CNT_W_DEF-1:0] div_t;
  typedef logic [CH_IDX_W-1:0]  ch_t;

  typedef struct packed {
    ch_t  ch;
    div_t div;
  } cfg_req_t;

  typedef enum logic {
    SLOT_EMPTY   = 1'b0,
    SLOT_PENDING = 1'b1
  } slot_state_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, divisor register, 50% toggle output and registered tick.
// The sync input is the phase-align request; it is tied low when that feature is not built.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_div,
  output logic             clk_out,
  output logic             tick,
  output logic             at_terminal,
  output logic             idle_load_ok
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;

  // >= keeps the counter bounded even if div ever drops below cnt
  assign at_terminal  = en & ~sync & (cnt_q >= div_q);
  assign idle_load_ok = ~en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= RST_DIV;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
      if (load_en) begin
        div_q <= load_div;
        cnt_q <= '0;
      end
    end else if (sync) begin
      cnt_q   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (at_terminal) begin
      cnt_q   <= '0;
      clk_out <= ~clk_out;
      tick    <= 1'b1;
      if (load_en) div_q <= load_div;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH clock dividers sharing a single-slot divisor update port.
// Optional macro CLK_DIV_PHASE_SYNC_EN adds sync_req to phase-align all enabled channels.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                      NUM_CH      = 2,
  parameter int                      CNT_W       = 27,
  parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIV = {27'd10000000, 27'd100000},
  localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
`ifdef CLK_DIV_PHASE_SYNC_EN
  ,
  input  logic              sync_req
`endif
);

  // Handshake: a request transfers on any cycle with cfg_valid & cfg_ready; the
  // requester holds cfg_ch/cfg_div stable while cfg_valid is high and not yet accepted.
  // The slot stores at most one request (CNT_W must not exceed CNT_W_DEF).

  slot_state_t       state_q, state_d;
  cfg_req_t          pend_q, pend_d;
  logic [NUM_CH-1:0] load_en;
  logic [NUM_CH-1:0] at_terminal;
  logic [NUM_CH-1:0] idle_load_ok;
  logic [CNT_W-1:0]  load_div;
  logic              sync_w;
  logic              ch_match;

`ifdef CLK_DIV_PHASE_SYNC_EN
  assign sync_w = sync_req;
`else
  assign sync_w = 1'b0;
`endif

  assign cfg_ready = (state_q == SLOT_EMPTY);
  assign load_div  = CNT_W'(pend_q.div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    load_en  = '0;
    ch_match = 1'b0;
    case (state_q)
      SLOT_EMPTY: begin
        if (cfg_valid) begin
          pend_d  = '{ch: ch_t'(cfg_ch), div: div_t'(cfg_div)};
          state_d = SLOT_PENDING;
        end
      end
      SLOT_PENDING: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (pend_q.ch == ch_t'(i)) begin
            ch_match = 1'b1;
            if (at_terminal[i] || idle_load_ok[i]) begin
              load_en[i] = 1'b1;
              state_d    = SLOT_EMPTY;
            end
          end
        end
        // No channel owns this index: drop the request
        if (!ch_match) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (DEFAULT_DIV[g*CNT_W +: CNT_W])
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .en           (en[g]),
      .sync         (sync_w),
      .load_en      (load_en[g]),
      .load_div     (load_div),
      .clk_out      (clk_out[g]),
      .tick         (tick[g]),
      .at_terminal  (at_terminal[g]),
      .idle_load_ok (idle_load_ok[g])
    );
  end

endmodule
